// File: rtl/csr_loader.sv
// csr_loader: turns a row-major (row, col, val) triplet stream
// into CSR value, column and row-pointer RAM writes.
module csr_loader #(
  parameter int NUM_ROWS = 4,
  parameter int DEPTH    = 16384
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [13:0] in_row,
  input  logic [31:0] in_col,
  input  logic [31:0] in_val,
  input  logic        in_last,
  output logic [13:0] val_addr,
  output logic [31:0] val_din,
  output logic        val_we,
  output logic [13:0] col_addr,
  output logic [31:0] col_din,
  output logic        col_we,
  output logic [13:0] row_addr,
  output logic [31:0] row_din,
  output logic        row_we,
  output logic [14:0] nnz_count,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [13:0] NR = 14'(NUM_ROWS);
  localparam logic [14:0] DP = 15'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FILL,
    S_FINAL,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [14:0] nnz;
  logic [14:0] fill_val;
  logic [13:0] cur_row;
  logic [13:0] target;
  logic        last_pend;

  logic        xfer;
  logic        bad;
  logic        jump;
  logic        can_start;
  logic [13:0] nxt_row;

  assign nnz_count = nnz;
  assign nxt_row   = cur_row + 14'd1;
  assign xfer      = (state == S_LOAD) && in_valid && in_ready;
  assign jump      = in_row != cur_row;
  assign can_start = start &&
                     ((state == S_IDLE) ||
                      (state == S_DONE) ||
                      (state == S_ERR));

  // A triplet is rejected if it goes backwards, runs off the
  // matrix, or would overflow the value/column RAMs.
  always_comb begin
    bad = 1'b0;
    if (in_row < cur_row) bad = 1'b1;
    if (in_row >= NR)     bad = 1'b1;
    if (nnz == DP)        bad = 1'b1;
  end

  // Load sequencer; every RAM port and status flag is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      nnz       <= '0;
      fill_val  <= '0;
      cur_row   <= '0;
      target    <= '0;
      last_pend <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      val_addr  <= '0;
      val_din   <= '0;
      val_we    <= 1'b0;
      col_addr  <= '0;
      col_din   <= '0;
      col_we    <= 1'b0;
      row_addr  <= '0;
      row_din   <= '0;
      row_we    <= 1'b0;
    end else begin
      val_we <= 1'b0;
      col_we <= 1'b0;
      row_we <= 1'b0;
      done   <= 1'b0;
      if (can_start) begin
        state    <= S_LOAD;
        nnz      <= '0;
        cur_row  <= '0;
        fill_val <= '0;
        error    <= 1'b0;
        in_ready <= 1'b1;
        busy     <= 1'b1;
        row_we   <= 1'b1;
        row_addr <= '0;
        row_din  <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
          S_LOAD: begin
            if (xfer && bad) begin
              state    <= S_ERR;
              error    <= 1'b1;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end else if (xfer) begin
              val_we   <= 1'b1;
              val_addr <= nnz[13:0];
              val_din  <= in_val;
              col_we   <= 1'b1;
              col_addr <= nnz[13:0];
              col_din  <= in_col;
              nnz      <= nnz + 15'd1;
              if (jump) begin
                fill_val  <= nnz;
                target    <= in_row;
                last_pend <= in_last;
                state     <= S_FILL;
                in_ready  <= 1'b0;
              end else if (in_last) begin
                state    <= S_FINAL;
                in_ready <= 1'b0;
              end
            end
          end
          S_FILL: begin
            row_we   <= 1'b1;
            row_addr <= nxt_row;
            row_din  <= {17'd0, fill_val};
            cur_row  <= nxt_row;
            if (nxt_row == target) begin
              if (last_pend) begin
                state <= S_FINAL;
              end else begin
                state    <= S_LOAD;
                in_ready <= 1'b1;
              end
            end
          end
          S_FINAL: begin
            row_we   <= 1'b1;
            row_addr <= nxt_row;
            row_din  <= {17'd0, nnz};
            cur_row  <= nxt_row;
            if (nxt_row == NR) begin
              state <= S_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          S_ERR: begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_loader.sv
// tb_csr_loader: directed and random triplet streams checked
// against a CSR reference model built from the raw triplet list.
module tb_csr_loader;

  localparam int NR = 4;
  localparam int DP = 8;
  localparam int MAXT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] in_row = '0;
  logic [31:0] in_col = '0;
  logic [31:0] in_val = '0;
  logic        in_last = 1'b0;
  logic [13:0] val_addr, col_addr, row_addr;
  logic [31:0] val_din, col_din, row_din;
  logic        val_we, col_we, row_we;
  logic [14:0] nnz_count;
  logic        busy, done, error;

  csr_loader #(.NUM_ROWS(NR), .DEPTH(DP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_val(in_val),
    .in_last(in_last),
    .val_addr(val_addr), .val_din(val_din), .val_we(val_we),
    .col_addr(col_addr), .col_din(col_din), .col_we(col_we),
    .row_addr(row_addr), .row_din(row_din), .row_we(row_we),
    .nnz_count(nnz_count), .busy(busy), .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAMs written by the DUT ports
  logic [31:0] m_val[DP];
  logic [31:0] m_col[DP];
  logic [31:0] m_row[NR+1];
  int n_vw, n_cw, n_rw, n_done;

  always @(posedge clk) begin
    if (val_we) begin
      if (int'(val_addr) < DP) m_val[val_addr] = val_din;
      n_vw++;
    end
    if (col_we) begin
      if (int'(col_addr) < DP) m_col[col_addr] = col_din;
      n_cw++;
    end
    if (row_we) begin
      if (int'(row_addr) <= NR) m_row[row_addr] = row_din;
      n_rw++;
    end
    if (done) n_done++;
  end

  task automatic clear_mem();
    for (int k = 0; k < DP; k++) begin
      m_val[k] = 32'hdeadbeef;
      m_col[k] = 32'hdeadbeef;
    end
    for (int k = 0; k <= NR; k++) m_row[k] = 32'hdeadbeef;
    n_vw = 0; n_cw = 0; n_rw = 0; n_done = 0;
  endtask

  // stimulus stream
  int t_n;
  int t_row[MAXT];
  int t_col[MAXT];
  int t_val[MAXT];
  bit t_last[MAXT];

  // reference results
  int e_nnz, e_cnt;
  bit e_err;
  int e_val[DP];
  int e_col[DP];
  int e_rowof[DP];
  int e_rp[NR+1];
  int e_wait[MAXT];

  task automatic model();
    int cur, n, pj;
    cur = 0; n = 0; pj = 0;
    e_err = 0; e_cnt = t_n;
    for (int i = 0; i < t_n; i++) begin
      e_wait[i] = pj;
      if (t_row[i] < cur || t_row[i] >= NR || n == DP) begin
        e_err = 1; e_cnt = i + 1;
        break;
      end
      e_val[n] = t_val[i];
      e_col[n] = t_col[i];
      e_rowof[n] = t_row[i];
      n++;
      pj = t_row[i] - cur;
      cur = t_row[i];
      if (t_last[i]) begin
        e_cnt = i + 1;
        break;
      end
    end
    e_nnz = n;
    for (int r = 0; r <= NR; r++) begin
      e_rp[r] = 0;
      for (int k = 0; k < n; k++)
        if (e_rowof[k] < r) e_rp[r]++;
    end
  endtask

  task automatic set_t(input int i, input int r, input int c,
                       input int v, input bit l);
    t_row[i] = r; t_col[i] = c; t_val[i] = v; t_last[i] = l;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input int i, output int w);
    bit ok;
    @(negedge clk);
    in_valid = 1'b1;
    in_row = 14'(t_row[i]);
    in_col = t_col[i];
    in_val = t_val[i];
    in_last = t_last[i];
    w = 0; ok = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      w++;
    end
    check("xfer_timeout", 32'(ok), 1);
  endtask

  task automatic run_stream(input bit mid_start);
    int w;
    bit seen;
    clear_mem();
    model();
    pulse_start();
    check("start_err_clr", 32'(error), 0);
    check("start_busy", 32'(busy), 1);
    for (int i = 0; i < e_cnt; i++) begin
      send(i, w);
      check($sformatf("wait%0d", i), w, e_wait[i]);
      if (mid_start && i == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("mid_start_nnz", 32'(nnz_count), 1);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    if (e_err) begin
      check("err_flag", 32'(error), 1);
      check("err_ready", 32'(in_ready), 0);
      check("err_busy", 32'(busy), 0);
      repeat (3) @(negedge clk);
      check("err_vw", n_vw, e_nnz);
      check("err_nnz", 32'(nnz_count), e_nnz);
    end else begin
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      check("done_seen", 32'(seen), 1);
      repeat (3) @(negedge clk);
      check("done_cnt", n_done, 1);
      check("nnz_count", 32'(nnz_count), e_nnz);
      check("idle_busy", 32'(busy), 0);
      check("ok_error", 32'(error), 0);
      check("vw_cnt", n_vw, e_nnz);
      check("cw_cnt", n_cw, e_nnz);
      check("rw_cnt", n_rw, NR + 1);
      for (int r = 0; r <= NR; r++)
        check($sformatf("rp%0d", r), m_row[r], e_rp[r]);
    end
    for (int k = 0; k < e_nnz; k++) begin
      check($sformatf("val%0d", k), m_val[k], e_val[k]);
      check($sformatf("col%0d", k), m_col[k], e_col[k]);
    end
  endtask

  task automatic base_stream();
    t_n = 3;
    set_t(0, 0, 1, 10, 0);
    set_t(1, 0, 3, 20, 0);
    set_t(2, 2, 0, 30, 1);
  endtask

  initial begin
    int w, rw0, r;
    #2 reset = 1'b0;
    #1;
    check("rst_strobes",
          32'({val_we, col_we, row_we, in_ready, busy, done, error}),
          0);
    check("rst_nnz", 32'(nnz_count), 0);
    check("rst_addr", 32'({val_addr, row_addr}), 0);
    @(negedge clk);
    reset = 1'b1;

    // valid is ignored while idle
    clear_mem();
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(in_ready), 0);
    check("idle_vw", n_vw, 0);
    in_valid = 1'b0;

    // basic load, fill rows 1,2, then final rows 3,4
    base_stream();
    run_stream(0);

    // start during load is ignored
    base_stream();
    run_stream(1);

    // row goes backwards
    t_n = 2;
    set_t(0, 1, 0, 5, 0);
    set_t(1, 0, 0, 6, 1);
    run_stream(0);
    check("err_val1", m_val[1], 32'hdeadbeef);

    // row beyond matrix; also verifies start cleared error
    t_n = 1;
    set_t(0, 4, 7, 9, 1);
    run_stream(0);

    // value RAM full
    t_n = 9;
    for (int i = 0; i < 9; i++) set_t(i, 0, i, 100 + i, i == 8);
    run_stream(0);

    // exactly full, last row only
    t_n = 8;
    for (int i = 0; i < 8; i++) set_t(i, 3, i, 200 + i, i == 7);
    run_stream(0);

    // reset during fill aborts everything
    base_stream();
    clear_mem();
    pulse_start();
    for (int i = 0; i < 3; i++) send(i, w);
    #3 reset = 1'b0;
    #1;
    check("abort_strobes",
          32'({val_we, col_we, row_we, in_ready, busy, done, error}),
          0);
    check("abort_nnz", 32'(nnz_count), 0);
    in_valid = 1'b0;
    in_last = 1'b0;
    rw0 = n_rw;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("abort_rw", n_rw - rw0, 0);
    check("abort_ready", 32'(in_ready), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", n_done, 0);

    // random streams
    for (int it = 0; it < 40; it++) begin
      t_n = int'($urandom_range(1, 10));
      r = 0;
      for (int i = 0; i < t_n; i++) begin
        if ($urandom_range(0, 11) == 0) begin
          if ($urandom_range(0, 1) == 0 || r == 0)
            t_row[i] = int'($urandom_range(NR, NR + 3));
          else
            t_row[i] = r - 1;
        end else begin
          r = r + int'($urandom_range(0, 2));
          if (r > NR - 1) r = NR - 1;
          t_row[i] = r;
        end
        t_col[i] = int'($urandom);
        t_val[i] = int'($urandom);
        t_last[i] = (i == t_n - 1);
      end
      run_stream(0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/csr_loader.md
CSR_LOADER -- requirements
Module: csr_loader

Interface
REQ-001 Parameter: NUM_ROWS, default 4, number of matrix rows (1..16383); row-pointer table has NUM_ROWS+1 entries.
REQ-002 Parameter: DEPTH, default 16384, capacity of the value and column RAMs in entries.
REQ-003 Ports: clk  in  1  sole clock, all logic on rising edge.
REQ-004 Ports: reset  in  1  asynchronous, active-low reset.
REQ-005 Ports: start  in  1  one-cycle pulse that begins a load.
REQ-006 Ports: in_valid  in  1 / in_ready  out  1  triplet handshake; transfer occurs when both are high on a rising edge.
REQ-007 Ports: in_row  in  14  row index; in_col  in  32  column index; in_val  in  32  element value; in_last  in  1  final triplet.
REQ-008 Ports: val_addr  out  14 / val_din  out  32 / val_we  out  1  value-RAM write port.
REQ-009 Ports: col_addr  out  14 / col_din  out  32 / col_we  out  1  column-RAM write port.
REQ-010 Ports: row_addr  out  14 / row_din  out  32 / row_we  out  1  row-pointer-RAM write port.
REQ-011 Ports: nnz_count  out  15  elements written; busy  out  1; done  out  1; error  out  1.

Function
REQ-012 The block SHALL be the CSR writer: it turns a row-major triplet stream into value, column and row-pointer RAM contents readable by the SpMV datapath.
REQ-013 States SHALL be IDLE, LOAD, FILL, FINAL, DONE, ERR. All RAM write outputs SHALL be registered. Each write strobe SHALL be high for exactly one cycle per write.
REQ-014 IDLE: in_ready=0, busy=0. in_valid SHALL be ignored. On start: go to LOAD, clear nnz and cur_row to 0, and clear error. On the next cycle, write row_ptr[0]=0.
REQ-015 LOAD: in_ready=1, busy=1.
REQ-016 On a transfer with in_row==cur_row: the next cycle SHALL write val[nnz]=in_val and col[nnz]=in_col, and nnz SHALL increment.
REQ-017 On a transfer with cur_row<in_row<NUM_ROWS: write val/col at nnz the same way, latch fill_val=nnz (pre-increment), increment nnz, and go to FILL with target=in_row.
REQ-018 FILL: in_ready=0. Each cycle SHALL write row_ptr[cur_row+1]=fill_val and increment cur_row. When cur_row reaches target, go to LOAD, or to FINAL if the triggering triplet had in_last=1.
REQ-019 A transfer with in_last=1 and no pending fill SHALL go to FINAL after its val/col write.
REQ-020 FINAL: in_ready=0. One row_ptr write per cycle with row_ptr[cur_row+1]=nnz, for cur_row+1 up to NUM_ROWS inclusive, then go to DONE.
REQ-021 DONE: done=1 for exactly one cycle, then go to IDLE. nnz_count SHALL hold its value until the next start.
REQ-022 ERR is entered on a transfer with in_row<cur_row, in_row>=NUM_ROWS, or nnz==DEPTH. The offending triplet SHALL NOT be written.
REQ-023 In ERR: error=1 (sticky), in_ready=0, no writes, busy=0. A start pulse SHALL restart the load as in REQ-014.
REQ-024 A start pulse while busy=1 SHALL be ignored.
REQ-025 Width rules: row_din = zero-extended nnz (32 bits); val_addr = col_addr = nnz[13:0]; row_addr = row index.

Reset
REQ-026 While reset=0, asynchronously and regardless of clk: state=IDLE; nnz, cur_row, fill_val, nnz_count=0; every output=0 (including all we strobes, in_ready, busy, done, error).
REQ-027 A reset asserted mid-FILL or mid-FINAL SHALL abort with no further writes. RAM contents are undefined until the next complete load.

Verification
REQ-028 NUM_ROWS=4; start; triplets (0,1,10),(0,3,20),(2,0,30,last) -> val=[10,20,30], col=[1,3,0], row_ptr=[0,2,2,3,3], done pulse once, nnz_count=3.
REQ-029 Same stream with in_valid held high -> in_ready low for exactly 2 cycles after the third transfer (FILL rows 1,2), then 2 FINAL writes, then done.
REQ-030 Triplets (1,0,5),(0,0,6) -> error=1 after the second transfer, val[1] never written, in_ready=0; a following start clears error.
REQ-031 Triplet with in_row=4 at NUM_ROWS=4 -> error=1, no val/col write.
REQ-032 reset driven low during the FILL of REQ-028 -> all outputs 0 immediately; after release: idle, no writes, in_ready=0.
REQ-033 start pulsed during LOAD -> ignored, nnz unchanged, stream completes as in REQ-028.
